// File: rtl/fp_round_pkg.sv
// rtl/fp_round_pkg.sv - shared rounding-mode encodings and default float field widths
package fp_round_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

endpackage

// File: rtl/round_inc_decide.sv
// rtl/round_inc_decide.sv - decides whether the truncated mantissa must be bumped by one ulp
module round_inc_decide
  import fp_round_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round,
  input  logic       sticky,
  input  logic [1:0] mode,
  output logic       inc
);

  logic any;

  assign any = guard | round | sticky;

  always_comb begin
    inc = 1'b0;
    case (mode)
      // A pure tie (G only) falls back on lsb, giving round-half-to-even.
      RM_RNE:  inc = guard & (round | sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & any;
      RM_RDN:  inc = sign & any;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/rounding_module.sv
// rtl/rounding_module.sv - rounds {sign, exp, man, G, R, S} to binary32 with one registered stage
module rounding_module
  import fp_round_pkg::*;
#(
  parameter int DATA_W = 1 + EXP_W_DEF + MAN_W_DEF + 3,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        rouding_mode,
  output logic [DATA_W-4:0] result,
  output logic              inexact,
  output logic              overflow
);

  localparam int MAN_W = DATA_W - 1 - EXP_W - 3;
  localparam int MAG_W = EXP_W + MAN_W;

  logic             sign;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;
  logic             guard;
  logic             round;
  logic             sticky;
  logic             special;
  logic             inc_raw;
  logic             inc;
  logic [MAG_W-1:0] mag_rnd;
  logic             inexact_c;
  logic             overflow_c;

  assign sign     = data[DATA_W-1];
  assign exponent = data[DATA_W-2 -: EXP_W];
  assign mantissa = data[3 +: MAN_W];
  assign guard    = data[2];
  assign round    = data[1];
  assign sticky   = data[0];

  assign special = &exponent;

  round_inc_decide u_inc (
    .sign   (sign),
    .lsb    (mantissa[0]),
    .guard  (guard),
    .round  (round),
    .sticky (sticky),
    .mode   (rouding_mode),
    .inc    (inc_raw)
  );

  assign inc = inc_raw & ~special;

  // One add over {exp, man}: a mantissa carry naturally bumps the exponent and
  // leaves the mantissa zero, so carry into all-ones already encodes infinity.
  assign mag_rnd = {exponent, mantissa} + {{(MAG_W-1){1'b0}}, inc};

  assign overflow_c = ~special & (&mag_rnd[MAG_W-1 -: EXP_W]);
  assign inexact_c  = ~special & (guard | round | sticky);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      inexact  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= {sign, mag_rnd};
      inexact  <= inexact_c;
      overflow <= overflow_c;
    end
  end

endmodule

// File: tb/tb_rounding_module.sv
// tb/tb_rounding_module.sv - randomized and directed self-checking bench for rounding_module
module tb_rounding_module;

  logic        clk;
  logic        rst_n;
  logic [34:0] data;
  logic [1:0]  rouding_mode;
  logic [31:0] result;
  logic        inexact;
  logic        overflow;

  int checks;
  int failures;
  bit cmp_on;

  logic [31:0] m_result;
  logic        m_inexact;
  logic        m_overflow;

  rounding_module dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .rouding_mode (rouding_mode),
    .result       (result),
    .inexact      (inexact),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] mk(input logic s, input logic [7:0] e,
                                     input logic [22:0] m, input logic [2:0] grs);
    return {s, e, m, grs};
  endfunction

  // Reference: treat {G,R,S} as a fraction of one ulp in eighths and decide with plain arithmetic.
  function automatic void model(input logic [34:0] d, input logic [1:0] mode,
                                output logic [31:0] r, output logic i, output logic o);
    int unsigned e, rem;
    longint unsigned mag;
    bit s, up;
    s   = d[34];
    e   = d[33:26];
    rem = d[2:0];
    mag = longint'(e) * 64'd8388608 + longint'(d[25:3]);
    if (e == 255) begin
      r = d[34:3];
      i = 1'b0;
      o = 1'b0;
      return;
    end
    case (mode)
      2'd0:    up = (rem > 4) || (rem == 4 && (mag % 2 == 1));
      2'd1:    up = 1'b0;
      2'd2:    up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    if (up) mag = mag + 1;
    r = {s, mag[30:0]};
    i = (rem != 0);
    o = ((mag >> 23) == 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result   = '0;
      m_inexact  = 1'b0;
      m_overflow = 1'b0;
    end else begin
      model(data, rouding_mode, m_result, m_inexact, m_overflow);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_result", result, m_result);
      chk("cyc_inexact", {31'd0, inexact}, {31'd0, m_inexact});
      chk("cyc_overflow", {31'd0, overflow}, {31'd0, m_overflow});
    end
  end

  task automatic directed(input string name, input logic [34:0] d, input logic [1:0] mode,
                          input logic [31:0] w_res, input logic w_inx, input logic w_ovf);
    logic [31:0] mr;
    logic mi, mo;
    @(negedge clk);
    data = d;
    rouding_mode = mode;
    model(d, mode, mr, mi, mo);
    chk({name, "_model"}, {mr[31:2], mi, mo}, {w_res[31:2], w_inx, w_ovf});
    chk({name, "_model_lo"}, {30'd0, mr[1:0]}, {30'd0, w_res[1:0]});
    @(posedge clk);
    #1;
    chk({name, "_result"}, result, w_res);
    chk({name, "_inexact"}, {31'd0, inexact}, {31'd0, w_inx});
    chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, w_ovf});
  endtask

  initial begin
    logic [7:0]  e;
    logic [22:0] m;
    checks = 0;
    failures = 0;
    cmp_on = 1'b0;
    data = '0;
    rouding_mode = 2'b00;
    rst_n = 1'b0;
    #1;
    data = mk(0, 8'h82, 23'h000200, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_flags", {30'd0, inexact, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    directed("rne_below", mk(0, 8'h82, 23'h000200, 3'b010), 2'd0, 32'h41000200, 1, 0);
    directed("rne_exact", mk(0, 8'h82, 23'h000200, 3'b000), 2'd0, 32'h41000200, 0, 0);
    directed("rne_tie_even", mk(0, 8'h82, 23'h000200, 3'b100), 2'd0, 32'h41000200, 1, 0);
    directed("rne_tie_odd", mk(0, 8'h82, 23'h000201, 3'b100), 2'd0, 32'h41000202, 1, 0);
    directed("rne_above", mk(0, 8'h82, 23'h000200, 3'b101), 2'd0, 32'h41000201, 1, 0);
    directed("rtz", mk(0, 8'h82, 23'h000900, 3'b111), 2'd1, 32'h41000900, 1, 0);
    directed("rup_carry", mk(0, 8'h82, 23'h7FFFFF, 3'b001), 2'd2, 32'h41800000, 1, 0);
    directed("rup_neg", mk(1, 8'h82, 23'h000005, 3'b111), 2'd2, 32'hC1000005, 1, 0);
    directed("rdn_neg", mk(1, 8'h82, 23'h000000, 3'b001), 2'd3, 32'hC1000001, 1, 0);
    directed("rdn_pos", mk(0, 8'h82, 23'h000005, 3'b111), 2'd3, 32'h41000005, 1, 0);
    directed("ovf", mk(0, 8'hFE, 23'h7FFFFF, 3'b110), 2'd0, 32'h7F800000, 1, 1);
    directed("ovf_neg", mk(1, 8'hFE, 23'h7FFFFF, 3'b001), 2'd3, 32'hFF800000, 1, 1);
    directed("inf_pass", mk(0, 8'hFF, 23'h000000, 3'b111), 2'd0, 32'h7F800000, 0, 0);
    directed("nan_pass", mk(0, 8'hFF, 23'h7FFFFF, 3'b111), 2'd2, 32'h7FFFFFFF, 0, 0);
    directed("denorm_carry", mk(0, 8'h00, 23'h7FFFFF, 3'b101), 2'd0, 32'h00800000, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0:       e = 8'hFE;
        1:       e = 8'hFF;
        2:       e = 8'h00;
        default: e = 8'($urandom);
      endcase
      m = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      data = mk(1'($urandom), e, m, 3'($urandom));
      rouding_mode = 2'($urandom);
    end

    // Asynchronous reset between edges, then the first edge after release.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'h0);
    chk("async_rst_flags", {30'd0, inexact, overflow}, 32'h0);
    @(negedge clk);
    data = mk(0, 8'h82, 23'h000201, 3'b100);
    rouding_mode = 2'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_result", result, 32'h41000202);
    chk("post_rst_inexact", {31'd0, inexact}, 32'd1);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rounding_module.md
Name: rounding_module

Overview:
- Rounds an extended-precision single-precision float to IEEE-754 binary32.
- Input word: sign, 8-bit exponent, 23-bit mantissa, then 3 extra bits: guard, round, sticky.
- Sits after the FP adder/multiplier normalisation stage. Output is registered with one-cycle latency.
- Supports the four IEEE rounding directions, selected per cycle.

Parameters:
- DATA_W, 35: total input width. Layout is {sign, exponent, mantissa, G, R, S}.
- EXP_W, 8: exponent field width.
- MAN_W, derived = DATA_W-1-EXP_W-3 (23 by default): mantissa field width, localparam.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  DATA_W  unrounded value: [DATA_W-1] sign, next EXP_W exponent, next MAN_W mantissa, [2] guard, [1] round, [0] sticky.
- rouding_mode  in  2  rounding direction: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- result  out  DATA_W-3  rounded {sign, exponent, mantissa}.
- inexact  out  1  any of G/R/S was nonzero on a finite input.
- overflow  out  1  rounding carried the exponent to all-ones.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). The polarity and synchronicity are fixed.
- Reset: result = 0, inexact = 0, overflow = 0, applied immediately on rst_n low.
- Latency: combinational rounding, registered on every rising clk. The output reflects the data and rouding_mode sampled on the previous edge. There is no handshake and no stall.
- Increment decision, with lsb = mantissa[0] and any = G|R|S:
  - Mode 00: inc = G & (R | S | lsb). A tie (G=1, R=S=0) rounds to even.
  - Mode 01: inc = 0 (truncate).
  - Mode 10: inc = ~sign & any.
  - Mode 11: inc = sign & any.
- Rounding arithmetic: {exponent, mantissa} + inc as a single (EXP_W+MAN_W)-bit add. A mantissa carry-out increments the exponent and zeroes the mantissa. Sign is unchanged.
- Overflow: if the post-add exponent is all-ones (input exponent 0xFE with mantissa all-ones and inc=1), result = signed infinity (mantissa 0) and overflow = 1.
- Special inputs: an input exponent that is all-ones (Inf/NaN) passes through unchanged. In that case inc = 0, inexact = 0, overflow = 0.
- inexact = any for every non-special input, including mode 01 where no increment occurs.
- Denormals and zero (exponent 0): same rule. A carry out of the mantissa into exponent 1 is legal.
- Reset asserted mid-stream: outputs clear immediately. The first valid result appears one edge after rst_n deasserts.

Decomposition:
- Shared package fp_round_pkg holds:
  - the rounding mode constants RM_RNE=2'b00, RM_RTZ=2'b01, RM_RUP=2'b10, RM_RDN=2'b11;
  - the default EXP_W/MAN_W.
- One natural combinational sub-module, round_inc_decide (inputs sign, lsb, G, R, S, mode; output inc). The top level handles the add, the special-case and overflow logic, and the output registers.

Test Plan:
- Mode 00, data=0_10000010_00000000000001000000000_010 -> result=0x41000200, inexact=1. With G/R/S=000 -> 0x41000200, inexact=0.
- Mode 00 tie-to-even: mantissa 0x000200 with GRS=100 -> 0x41000200. Mantissa 0x000201 with GRS=100 -> 0x41000202. Both inexact=1.
- Mode 01, mantissa 0x000900 with GRS=111 -> 0x41000900 (truncated), inexact=1.
- Mode 10, sign 0, exp 0x82, mantissa all-ones, GRS=001 -> 0x41800000 (exponent carry). Mode 11 with sign 1, exp 0x82, mantissa 0, GRS=001 -> 0xC1000001.
- Overflow: mode 00, exp 0xFE, mantissa all-ones, GRS=110 -> 0x7F800000, overflow=1. Input 0x7F800000 with GRS=111 -> passthrough, inexact=0.
- Reset: drive rst_n low between clock edges -> all outputs 0 immediately. After release, the first edge registers the current input.
